// File: rtl/bpm_estimator.sv
// bpm_estimator: beat-interval tempo estimator with 4-tap moving average and peak amplitude tracking.
// Feeds BPM_estimate and pulse_amplitude to the ADSR brightness filter.
module bpm_estimator #(
    parameter int TICK_CYCLES = 50_000,
    parameter int MIN_BPM     = 40,
    parameter int MAX_BPM     = 200,
    parameter int BPM_W       = $clog2(MAX_BPM + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             beat_in,
    input  logic [15:0]      sample_in,
    input  logic             sample_valid,
    output logic [BPM_W-1:0] BPM_estimate,
    output logic [7:0]       pulse_amplitude,
    output logic             bpm_valid,
    output logic             bpm_update,
    output logic [10:0]      interval_ms
);
    localparam int TW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
    localparam logic [10:0] MIN_INT = 11'(60000 / MAX_BPM);
    localparam logic [10:0] MAX_INT = 11'(60000 / MIN_BPM);
    localparam logic [10:0] SAT_INT = MAX_INT + 11'd1;

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE, UPDATE} state_t;
    state_t r_state, w_next;

    logic [TW-1:0]          r_tick;
    logic [10:0]            r_int, r_cap, r_rem, w_rem;
    logic [15:0]            r_peak, r_quo, w_mag;
    logic [7:0]             r_pamp;
    logic [3:0]             r_cnt;
    logic [3:0][BPM_W-1:0]  r_hist;
    logic                   r_fin;
    logic [11:0]            w_sh;
    logic [BPM_W-1:0]       w_q;
    logic [BPM_W+1:0]       w_sum;
    logic                   w_ms_tick, w_timeout, w_accept, w_clear, w_ge;

    assign w_ms_tick = r_tick == TW'(TICK_CYCLES - 1);
    assign w_timeout = r_int == SAT_INT;
    assign w_accept  = r_state == MEASURE && !w_timeout && beat_in && r_int >= MIN_INT && r_int <= MAX_INT;
    assign w_clear   = w_accept || (r_state == IDLE && beat_in);
    // -32768 has no positive twin, so it saturates to 32767
    assign w_mag = !sample_in[15] ? sample_in : sample_in == 16'h8000 ? 16'h7FFF : -sample_in;
    // One restoring-division step: remainder shifts in the next dividend bit
    assign w_sh  = {r_rem, r_quo[15]};
    assign w_ge  = w_sh >= {1'b0, r_cap};
    assign w_rem = w_ge ? 11'(w_sh - {1'b0, r_cap}) : 11'(w_sh);
    assign w_q   = r_quo > 16'(MAX_BPM) ? BPM_W'(MAX_BPM) :
                   r_quo < 16'(MIN_BPM) ? BPM_W'(MIN_BPM) : r_quo[BPM_W-1:0];
    assign w_sum = (BPM_W+2)'(r_hist[0]) + (BPM_W+2)'(r_hist[1]) +
                   (BPM_W+2)'(r_hist[2]) + (BPM_W+2)'(r_hist[3]);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = beat_in ? MEASURE : IDLE;
            MEASURE: w_next = w_timeout ? IDLE : w_accept ? DIVIDE : MEASURE;
            DIVIDE:  w_next = r_cnt == 4'd15 ? UPDATE : DIVIDE;
            UPDATE:  w_next = MEASURE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_tick          <= '0;
            r_int           <= '0;
            r_cap           <= '0;
            r_rem           <= '0;
            r_quo           <= '0;
            r_peak          <= '0;
            r_pamp          <= '0;
            r_cnt           <= '0;
            r_hist          <= '0;
            r_fin           <= 1'b0;
            BPM_estimate    <= '0;
            pulse_amplitude <= '0;
            bpm_valid       <= 1'b0;
            bpm_update      <= 1'b0;
            interval_ms     <= '0;
        end else begin
            r_state    <= w_next;
            r_tick     <= w_ms_tick ? '0 : r_tick + TW'(1);
            r_int      <= w_clear ? '0 : (w_ms_tick && !w_timeout) ? r_int + 11'd1 : r_int;
            r_peak     <= w_clear ? (sample_valid ? w_mag : '0) :
                          (sample_valid && w_mag > r_peak) ? w_mag : r_peak;
            r_fin      <= r_state == UPDATE;
            bpm_update <= r_fin;
            if (w_accept) begin
                r_cap  <= r_int;
                r_pamp <= r_peak[15:8];
                r_cnt  <= '0;
                r_rem  <= '0;
                r_quo  <= 16'd60000;
            end
            if (r_state == DIVIDE) begin
                r_cnt <= r_cnt + 4'd1;
                r_rem <= w_rem;
                r_quo <= {r_quo[14:0], w_ge};
            end
            if (r_state == UPDATE)
                r_hist <= bpm_valid ? {r_hist[2:0], w_q} : {4{w_q}};
            if (r_fin) begin
                BPM_estimate    <= w_sum[BPM_W+1:2];
                pulse_amplitude <= r_pamp;
                interval_ms     <= r_cap;
                bpm_valid       <= 1'b1;
            end
            if (r_state == MEASURE && w_timeout) begin
                BPM_estimate    <= '0;
                pulse_amplitude <= '0;
                bpm_valid       <= 1'b0;
                r_hist          <= '0;
            end
        end
    end
endmodule

// File: tb/tb_bpm_estimator.sv
// tb_bpm_estimator: directed tests of bpm_estimator with 10-cycle ms ticks.
// Beats are placed mid-tick so every measured interval is exact.
module tb_bpm_estimator;
    logic        clk = 1'b0;
    logic        reset_n, beat_in, sample_valid, bpm_valid, bpm_update;
    logic [15:0] sample_in;
    logic [7:0]  BPM_estimate, pulse_amplitude;
    logic [10:0] interval_ms;
    int errors = 0, checks = 0, since = 0, n_upd = 0, u0 = 0;

    bpm_estimator #(.TICK_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .beat_in(beat_in), .sample_in(sample_in),
        .sample_valid(sample_valid), .BPM_estimate(BPM_estimate),
        .pulse_amplitude(pulse_amplitude), .bpm_valid(bpm_valid),
        .bpm_update(bpm_update), .interval_ms(interval_ms)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (bpm_update === 1'b1) n_upd++;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        since += n;
    endtask

    task automatic beat_now();
        beat_in = 1'b1;
        @(negedge clk);
        beat_in = 1'b0;
        since = 0;
    endtask

    // Next beat is sampled exactly gap_ms*10 edges after the previous one
    task automatic fire(input int gap_ms);
        cyc(gap_ms * 10 - 1 - since);
        beat_now();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; beat_in = 1'b0; sample_in = '0; sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (BPM_estimate !== 8'd0) begin errors++; $display("FAIL reset_bpm: got %0d exp 0", BPM_estimate); end
        checks++; if (pulse_amplitude !== 8'd0) begin errors++; $display("FAIL reset_pulse: got %0d exp 0", pulse_amplitude); end
        checks++; if (bpm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bpm_valid); end
        checks++; if (bpm_update !== 1'b0) begin errors++; $display("FAIL reset_update: got %b exp 0", bpm_update); end
        checks++; if (interval_ms !== 11'd0) begin errors++; $display("FAIL reset_interval: got %0d exp 0", interval_ms); end
        reset_n = 1'b1;
        since = 0;
    endtask

    task automatic test_lock();
        cyc(4);
        beat_now();
        cyc(30);
        checks++; if (n_upd !== 0) begin errors++; $display("FAIL lock_idle_update: got %0d exp 0", n_upd); end
        fire(500);
        cyc(17);
        checks++; if (bpm_update !== 1'b0 || bpm_valid !== 1'b0) begin errors++; $display("FAIL lock_early: got upd=%b valid=%b exp 0 0", bpm_update, bpm_valid); end
        cyc(1);
        checks++; if (bpm_update !== 1'b1) begin errors++; $display("FAIL lock_update: got %b exp 1", bpm_update); end
        checks++; if (BPM_estimate !== 8'd120) begin errors++; $display("FAIL lock_bpm: got %0d exp 120", BPM_estimate); end
        checks++; if (bpm_valid !== 1'b1) begin errors++; $display("FAIL lock_valid: got %b exp 1", bpm_valid); end
        checks++; if (interval_ms !== 11'd500) begin errors++; $display("FAIL lock_interval: got %0d exp 500", interval_ms); end
        cyc(1);
        checks++; if (bpm_update !== 1'b0) begin errors++; $display("FAIL lock_update_width: got %b exp 0", bpm_update); end
        fire(500);
        cyc(18);
        checks++; if (BPM_estimate !== 8'd120) begin errors++; $display("FAIL lock_hold: got %0d exp 120", BPM_estimate); end
    endtask

    task automatic test_bounce();
        fire(100);
        u0 = n_upd;
        cyc(30);
        checks++; if (n_upd !== u0) begin errors++; $display("FAIL bounce_no_update: got %0d exp %0d", n_upd, u0); end
        fire(400);
        cyc(19);
        checks++; if (n_upd - u0 !== 1) begin errors++; $display("FAIL bounce_updates: got %0d exp 1", n_upd - u0); end
        checks++; if (BPM_estimate !== 8'd120) begin errors++; $display("FAIL bounce_bpm: got %0d exp 120", BPM_estimate); end
        checks++; if (interval_ms !== 11'd500) begin errors++; $display("FAIL bounce_interval: got %0d exp 500", interval_ms); end
    endtask

    task automatic test_ramp();
        int exp_b[4] = '{130, 140, 150, 160};
        for (int i = 0; i < 4; i++) begin
            fire(375);
            cyc(18);
            checks++; if (BPM_estimate !== 8'(exp_b[i])) begin errors++; $display("FAIL ramp_bpm[%0d]: got %0d exp %0d", i, BPM_estimate, exp_b[i]); end
            checks++; if (interval_ms !== 11'd375) begin errors++; $display("FAIL ramp_interval[%0d]: got %0d exp 375", i, interval_ms); end
        end
    endtask

    task automatic test_bounds();
        int gap[3]   = '{300, 1500, 700};
        int exp_b[3] = '{170, 140, 121};
        int exp_p[3] = '{0, 0, 8'h7F};
        for (int i = 0; i < 3; i++) begin
            fire(gap[i]);
            cyc(18);
            checks++; if (BPM_estimate !== 8'(exp_b[i])) begin errors++; $display("FAIL bounds_bpm[%0d]: got %0d exp %0d", i, BPM_estimate, exp_b[i]); end
            checks++; if (interval_ms !== 11'(gap[i])) begin errors++; $display("FAIL bounds_interval[%0d]: got %0d exp %0d", i, interval_ms, gap[i]); end
            checks++; if (pulse_amplitude !== 8'(exp_p[i])) begin errors++; $display("FAIL bounds_pulse[%0d]: got %h exp %h", i, pulse_amplitude, exp_p[i]); end
            if (i == 1) begin
                cyc(100);
                sample_valid = 1'b1;
                sample_in = 16'h1234; cyc(1);
                sample_in = 16'hC000; cyc(1);
                sample_in = 16'h8000; cyc(1);
                sample_valid = 1'b0;
                sample_in = 16'h0000;
            end
        end
    endtask

    task automatic test_timeout();
        cyc(15004 - since);
        u0 = n_upd;
        checks++; if (bpm_valid !== 1'b1 || BPM_estimate !== 8'd121) begin errors++; $display("FAIL timeout_early: got valid=%b bpm=%0d exp 1 121", bpm_valid, BPM_estimate); end
        cyc(6);
        checks++; if (bpm_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b exp 0", bpm_valid); end
        checks++; if (BPM_estimate !== 8'd0) begin errors++; $display("FAIL timeout_bpm: got %0d exp 0", BPM_estimate); end
        checks++; if (pulse_amplitude !== 8'd0) begin errors++; $display("FAIL timeout_pulse: got %h exp 0", pulse_amplitude); end
        checks++; if (n_upd !== u0) begin errors++; $display("FAIL timeout_update: got %0d exp %0d", n_upd, u0); end
    endtask

    task automatic test_relock();
        fire(1510);
        cyc(50);
        u0 = n_upd;
        sample_valid = 1'b1;
        sample_in = 16'h0100; cyc(1);
        sample_in = 16'hDCBB; cyc(1);
        sample_valid = 1'b0;
        sample_in = 16'h7000; cyc(1);
        sample_in = 16'h0000;
        fire(600);
        cyc(17);
        checks++; if (n_upd !== u0) begin errors++; $display("FAIL relock_early: got %0d exp %0d", n_upd, u0); end
        cyc(1);
        checks++; if (bpm_update !== 1'b1) begin errors++; $display("FAIL relock_update: got %b exp 1", bpm_update); end
        checks++; if (BPM_estimate !== 8'd100) begin errors++; $display("FAIL relock_bpm: got %0d exp 100", BPM_estimate); end
        checks++; if (bpm_valid !== 1'b1) begin errors++; $display("FAIL relock_valid: got %b exp 1", bpm_valid); end
        checks++; if (pulse_amplitude !== 8'h23) begin errors++; $display("FAIL relock_pulse: got %h exp 23", pulse_amplitude); end
        checks++; if (interval_ms !== 11'd600) begin errors++; $display("FAIL relock_interval: got %0d exp 600", interval_ms); end
    endtask

    task automatic test_reset_divide();
        fire(600);
        cyc(5);
        reset_n = 1'b0;
        #1;
        checks++; if (BPM_estimate !== 8'd0) begin errors++; $display("FAIL rstdiv_bpm: got %0d exp 0", BPM_estimate); end
        checks++; if (bpm_valid !== 1'b0) begin errors++; $display("FAIL rstdiv_valid: got %b exp 0", bpm_valid); end
        checks++; if (pulse_amplitude !== 8'd0) begin errors++; $display("FAIL rstdiv_pulse: got %h exp 0", pulse_amplitude); end
        checks++; if (interval_ms !== 11'd0) begin errors++; $display("FAIL rstdiv_interval: got %0d exp 0", interval_ms); end
        cyc(2);
        reset_n = 1'b1;
        u0 = n_upd;
        cyc(40);
        checks++; if (n_upd !== u0) begin errors++; $display("FAIL rstdiv_update: got %0d exp %0d", n_upd, u0); end
        checks++; if (bpm_valid !== 1'b0 || BPM_estimate !== 8'd0) begin errors++; $display("FAIL rstdiv_after: got valid=%b bpm=%0d exp 0 0", bpm_valid, BPM_estimate); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_bounce();
        test_ramp();
        test_bounds();
        test_timeout();
        test_relock();
        test_reset_divide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
